// File: rtl/asyncio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asyncio_pkg
// Purpose  : Widths and FSM encoding shared by the asyncio writer and reader.
// Revision : 1.0 - initial release
// ============================================================================
package asyncio_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int LENGTH_WIDTH  = 24;
   localparam int WORD_WIDTH    = 32;

   // Byte distance between consecutive words of a transfer
   localparam logic [ADDRESS_WIDTH-1:0] WORD_STRIDE = ADDRESS_WIDTH'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage : asyncio_pkg
`default_nettype wire

// File: rtl/asyncio_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : asyncio_writer_if
// Purpose  : Command, memory-load and AXI-stream signals of the asyncio writer.
//            master = writer side, slave = the environment around it.
// Revision : 1.0 - initial release
// ============================================================================
interface asyncio_writer_if #(
   parameter int ID_WIDTH        = 1,
   parameter int NO_OF_AXI_PORTS = 2
);
   // Transfer command
   logic [asyncio_pkg::LENGTH_WIDTH-1:0]      length;
   logic [asyncio_pkg::ADDRESS_WIDTH-1:0]     address;
   logic [ID_WIDTH-1:0]                       io_id;
   // Memory load port
   logic                                      memory_op_ready;
   logic [asyncio_pkg::WORD_WIDTH-1:0]        word_loaded;
   logic                                      memory_op_enable;
   // AXI-stream fan-out
   logic [NO_OF_AXI_PORTS-1:0]                axi_valid;
   logic [NO_OF_AXI_PORTS*asyncio_pkg::WORD_WIDTH-1:0] axi_data;
   logic [NO_OF_AXI_PORTS-1:0]                axi_ready;
   // Status
   logic [asyncio_pkg::ADDRESS_WIDTH-1:0]     address_out;
   logic [asyncio_pkg::LENGTH_WIDTH-1:0]      length_out;
   logic                                      busy;

   modport master (
      input  length, address, io_id, memory_op_ready, word_loaded, axi_ready,
      output memory_op_enable, axi_valid, axi_data, address_out, length_out, busy
   );

   modport slave (
      output length, address, io_id, memory_op_ready, word_loaded, axi_ready,
      input  memory_op_enable, axi_valid, axi_data, address_out, length_out, busy
   );

endinterface : asyncio_writer_if
`default_nettype wire

// File: rtl/asyncio_port_demux.sv
`default_nettype none
// ============================================================================
// Module   : asyncio_port_demux
// Purpose  : Steers one word onto the selected AXI-stream port. Unselected
//            ports, and all ports for an out-of-range id, see zero.
// Revision : 1.0 - initial release
// ============================================================================
module asyncio_port_demux
   import asyncio_pkg::*;
#(
   parameter int ID_WIDTH        = 1,
   parameter int NO_OF_AXI_PORTS = 2
) (
   input  wire logic [ID_WIDTH-1:0]                    id_i,
   input  wire logic                                   valid_i,
   input  wire logic [WORD_WIDTH-1:0]                  data_i,
   output logic      [NO_OF_AXI_PORTS-1:0]             valid_o,
   output logic      [NO_OF_AXI_PORTS*WORD_WIDTH-1:0]  data_o
);

   for (genvar p = 0; p < NO_OF_AXI_PORTS; p++) begin : g_port
      logic w_sel;
      // Zero-extended compare so ids beyond the port count select nothing
      assign w_sel = valid_i && (32'(id_i) == 32'(p));
      assign valid_o[p] = w_sel;
      assign data_o[p*WORD_WIDTH +: WORD_WIDTH] = w_sel ? data_i : '0;
   end

endmodule : asyncio_port_demux
`default_nettype wire

// File: rtl/asyncio_writer.sv
`default_nettype none
// ============================================================================
// Module   : asyncio_writer
// Purpose  : Loads a run of 32-bit words from memory, one request per word,
//            and streams each onto the AXI-stream port picked by io_id.
// Revision : 1.0 - initial release
// ============================================================================
module asyncio_writer
   import asyncio_pkg::*;
#(
   parameter int ID_WIDTH        = 1,
   parameter int NO_OF_AXI_PORTS = 2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   asyncio_writer_if.master bus
);

   state_t                    state_q;
   logic                      mem_en_q;
   logic                      send_q;
   logic [ADDRESS_WIDTH-1:0]  addr_q;
   logic [LENGTH_WIDTH-1:0]   len_q;
   logic [ID_WIDTH-1:0]       id_q;
   logic [WORD_WIDTH-1:0]     hold_q;

   logic                      w_port_ready;
   logic [NO_OF_AXI_PORTS-1:0]            w_valid;
   logic [NO_OF_AXI_PORTS*WORD_WIDTH-1:0] w_data;

   // Acceptance of the presented word: ready of the selected port, or an
   // immediate accept when the id points past the last port (word dropped)
   always_comb begin
      w_port_ready = 1'b1;
      for (int i = 0; i < NO_OF_AXI_PORTS; i++) begin
         if (32'(id_q) == 32'(i)) begin
            w_port_ready = bus.axi_ready[i];
         end
      end
   end

   // Transfer FSM: latch command in IDLE, one load per word, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mem_en_q <= 1'b0;
         send_q   <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         hold_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.length != '0) begin
                  addr_q   <= bus.address;
                  len_q    <= bus.length;
                  id_q     <= bus.io_id;
                  mem_en_q <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (bus.memory_op_ready) begin
                  hold_q   <= bus.word_loaded;
                  mem_en_q <= 1'b0;
                  send_q   <= 1'b1;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               if (w_port_ready) begin
                  send_q <= 1'b0;
                  addr_q <= addr_q + WORD_STRIDE;
                  len_q  <= len_q - LENGTH_WIDTH'(1);
                  if (len_q == LENGTH_WIDTH'(1)) begin
                     state_q <= IDLE;
                  end else begin
                     mem_en_q <= 1'b1;
                     state_q  <= LOAD;
                  end
               end
            end
            default: begin
               mem_en_q <= 1'b0;
               send_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   asyncio_port_demux #(
      .ID_WIDTH        (ID_WIDTH),
      .NO_OF_AXI_PORTS (NO_OF_AXI_PORTS)
   ) u_demux (
      .id_i    (id_q),
      .valid_i (send_q),
      .data_i  (hold_q),
      .valid_o (w_valid),
      .data_o  (w_data)
   );

   assign bus.memory_op_enable = mem_en_q;
   assign bus.axi_valid        = w_valid;
   assign bus.axi_data         = w_data;
   assign bus.address_out      = addr_q;
   assign bus.length_out       = len_q;
   assign bus.busy             = (state_q != IDLE);

endmodule : asyncio_writer
`default_nettype wire

// File: tb/tb_asyncio_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_asyncio_writer
// Purpose  : Self-checking bench: transfer-level reference model compared
//            every cycle, plus literal expectations per directed scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asyncio_writer;

   localparam int ID_W = 2;
   localparam int NP   = 2;

   logic clk = 1'b1;
   logic rst;
   always #5 clk = ~clk;

   asyncio_writer_if #(.ID_WIDTH(ID_W), .NO_OF_AXI_PORTS(NP)) bus ();

   asyncio_writer #(.ID_WIDTH(ID_W), .NO_OF_AXI_PORTS(NP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: words remaining, next address, word in flight
   logic [23:0] m_rem  = '0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_word = '0;
   logic [1:0]  m_id   = '0;
   bit          m_have = 1'b0;
   logic        m_acc;
   logic [31:0] load_q[$];
   logic [31:0] got_q[$];
   int          got_port_q[$];

   // Environment knobs
   int              mem_stall  = 0;
   int              bp_cycles  = 0;
   logic [NP-1:0]   ready_mask = '1;
   int              stall_cnt  = 0;
   int              bp_cnt     = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h9 + (a >> 2);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model advances on each edge from the inputs the DUT also sees
   always @(posedge clk) begin
      if (rst) begin
         m_rem = '0; m_addr = '0; m_word = '0; m_id = '0; m_have = 1'b0;
      end else if (m_rem == 0) begin
         if (bus.length != 0) begin
            m_rem = bus.length; m_addr = bus.address; m_id = bus.io_id; m_have = 1'b0;
         end
      end else if (!m_have) begin
         if (bus.memory_op_ready) begin
            m_word = bus.word_loaded;
            m_have = 1'b1;
            load_q.push_back(m_addr);
         end
      end else begin
         m_acc = (int'(m_id) < NP) ? bus.axi_ready[int'(m_id)] : 1'b1;
         if (m_acc) begin
            if (int'(m_id) < NP) begin
               got_q.push_back(m_word);
               got_port_q.push_back(int'(m_id));
            end
            m_have = 1'b0;
            m_addr = m_addr + 32'd4;
            m_rem  = m_rem - 24'd1;
         end
      end
   end

   // Memory responder: optional stall, then returns the word for address_out
   always @(negedge clk) begin
      if (bus.memory_op_enable === 1'b1) begin
         if (stall_cnt < mem_stall) begin
            stall_cnt++;
            bus.memory_op_ready = 1'b0;
            bus.word_loaded     = 32'h0;
         end else begin
            bus.memory_op_ready = 1'b1;
            bus.word_loaded     = mem_word(bus.address_out);
         end
      end else begin
         stall_cnt = 0;
         bus.memory_op_ready = 1'b0;
         bus.word_loaded     = 32'hDEAD_BEEF;
      end
   end

   // AXI sink: ready_mask, with a burst of backpressure on each presented word
   always @(negedge clk) begin
      if (bus.axi_valid !== '0 && bp_cnt < bp_cycles) begin
         bus.axi_ready = ready_mask & ~bus.axi_valid;
         bp_cnt++;
      end else begin
         bus.axi_ready = ready_mask;
         if (bus.axi_valid === '0) bp_cnt = 0;
      end
   end

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic [NP-1:0]    ev;
      logic [NP*32-1:0] ed;
      logic             eb;
      if (chk_en) begin
         eb = (m_rem != 0);
         ev = '0;
         ed = '0;
         if (m_have && int'(m_id) < NP) begin
            ev[int'(m_id)] = 1'b1;
            ed[32*int'(m_id) +: 32] = m_word;
         end
         chk("busy",        64'(bus.busy),             64'(eb));
         chk("mem_enable",  64'(bus.memory_op_enable), 64'(eb && !m_have));
         chk("axi_valid",   64'(bus.axi_valid),        64'(ev));
         chk("axi_data",    64'(bus.axi_data),         64'(ed));
         chk("address_out", 64'(bus.address_out),      64'(m_addr));
         chk("length_out",  64'(bus.length_out),       64'(m_rem));
      end
   end

   // Start a transfer and count busy cycles until the writer is idle again
   task automatic xfer(input logic [23:0] len, input logic [31:0] addr, input logic [1:0] id,
                       input int mid_at, input logic [23:0] mid_val, input int clr_at,
                       output int bc);
      bit done = 1'b0;
      load_q.delete(); got_q.delete(); got_port_q.delete();
      @(negedge clk);
      bus.length = len; bus.address = addr; bus.io_id = id;
      bc = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (i == mid_at) bus.length = mid_val;
         if (i == clr_at) bus.length = 24'd0;
         if (bus.busy === 1'b1) bc++;
         else begin done = 1'b1; break; end
      end
      chk("xfer_done", 64'(done), 64'd1);
   endtask

   initial begin
      int bc;
      int mem_en_seen;
      logic [5:0] pat;
      rst = 1'b1;
      bus.length = '0; bus.address = '0; bus.io_id = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy",   64'(bus.busy), 64'd0);
      chk("rst_mem_en", 64'(bus.memory_op_enable), 64'd0);
      chk("rst_valid",  64'(bus.axi_valid), 64'd0);
      chk("rst_data",   64'(bus.axi_data), 64'd0);
      chk("rst_addr",   64'(bus.address_out), 64'd0);
      chk("rst_len",    64'(bus.length_out), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic transfer to port 1
      ready_mask = 2'b10;
      xfer(24'd3, 32'd4, 2'd1, -1, 24'd0, 0, bc);
      chk("basic_cycles", 64'(bc), 64'd6);
      chk("basic_nwords", 64'(got_q.size()), 64'd3);
      chk("basic_nloads", 64'(load_q.size()), 64'd3);
      if (got_q.size() == 3) begin
         chk("basic_w0", 64'(got_q[0]), 64'hA);
         chk("basic_w1", 64'(got_q[1]), 64'hB);
         chk("basic_w2", 64'(got_q[2]), 64'hC);
         chk("basic_port", 64'(got_port_q[2]), 64'd1);
      end
      if (load_q.size() == 3) begin
         chk("basic_a0", 64'(load_q[0]), 64'd4);
         chk("basic_a1", 64'(load_q[1]), 64'd8);
         chk("basic_a2", 64'(load_q[2]), 64'd12);
      end
      chk("basic_addr_end", 64'(bus.address_out), 64'd16);
      chk("basic_len_end",  64'(bus.length_out), 64'd0);

      // Backpressure on port 0: 5 stalled cycles per word
      ready_mask = 2'b11; bp_cycles = 5;
      xfer(24'd2, 32'h40, 2'd0, -1, 24'd0, 0, bc);
      bp_cycles = 0;
      chk("bp_cycles", 64'(bc), 64'd14);
      chk("bp_nwords", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("bp_w0", 64'(got_q[0]), 64'h19);
         chk("bp_w1", 64'(got_q[1]), 64'h1A);
         chk("bp_port", 64'(got_port_q[0]), 64'd0);
      end

      // Memory stall of 4 cycles per load
      mem_stall = 4;
      xfer(24'd2, 32'h80, 2'd1, -1, 24'd0, 0, bc);
      mem_stall = 0;
      chk("stall_cycles", 64'(bc), 64'd12);
      chk("stall_nwords", 64'(got_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("stall_w0", 64'(got_q[0]), 64'h29);
         chk("stall_w1", 64'(got_q[1]), 64'h2A);
      end

      // Address wrap at the top of the space
      xfer(24'd2, 32'hFFFF_FFFC, 2'd1, -1, 24'd0, 0, bc);
      chk("wrap_cycles", 64'(bc), 64'd4);
      if (load_q.size() == 2) begin
         chk("wrap_a0", 64'(load_q[0]), 64'hFFFF_FFFC);
         chk("wrap_a1", 64'(load_q[1]), 64'h0);
      end else chk("wrap_nloads", 64'(load_q.size()), 64'd2);
      if (got_q.size() == 2) begin
         chk("wrap_w0", 64'(got_q[0]), 64'h4000_0008);
         chk("wrap_w1", 64'(got_q[1]), 64'h9);
      end
      chk("wrap_addr_end", 64'(bus.address_out), 64'd4);

      // Length changed to 7 mid-transfer must be ignored
      xfer(24'd3, 32'h200, 2'd0, 1, 24'd7, 3, bc);
      chk("midlen_cycles", 64'(bc), 64'd6);
      chk("midlen_nwords", 64'(got_q.size()), 64'd3);
      chk("midlen_len_end", 64'(bus.length_out), 64'd0);

      // Out-of-range id: words discarded, two cycles per word
      xfer(24'd3, 32'h300, 2'd3, -1, 24'd0, 0, bc);
      chk("badid_cycles", 64'(bc), 64'd6);
      chk("badid_nwords", 64'(got_q.size()), 64'd0);
      chk("badid_nloads", 64'(load_q.size()), 64'd3);
      chk("badid_addr_end", 64'(bus.address_out), 64'h30C);

      // Length held non-zero: one idle cycle between back-to-back transfers
      @(negedge clk);
      bus.length = 24'd1; bus.address = 32'h400; bus.io_id = 2'd1;
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = bus.busy;
         if (i == 5) bus.length = 24'd0;
      end
      chk("b2b_pattern", 64'(pat), 64'b011011);
      repeat (3) @(negedge clk);

      // Reset mid-transfer aborts and does not resume
      @(negedge clk);
      bus.length = 24'd3; bus.address = 32'h500; bus.io_id = 2'd1;
      @(negedge clk);
      bus.length = 24'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_busy",   64'(bus.busy), 64'd0);
      chk("abort_mem_en", 64'(bus.memory_op_enable), 64'd0);
      chk("abort_valid",  64'(bus.axi_valid), 64'd0);
      chk("abort_data",   64'(bus.axi_data), 64'd0);
      chk("abort_len",    64'(bus.length_out), 64'd0);
      rst = 1'b0;
      mem_en_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.memory_op_enable !== 1'b0 || bus.busy !== 1'b0) mem_en_seen++;
      end
      chk("abort_no_resume", 64'(mem_en_seen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_asyncio_writer
`default_nettype wire
